// File: rtl/vga_timing_pkg.sv
// Shared timing definitions for sync generators and sync receivers.
// Holds the receiver FSM encoding and the 640x480 reference timing.
package vga_timing_pkg;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] MEASURE = 2'b01;
  localparam logic [1:0] VERIFY  = 2'b10;
  localparam logic [1:0] LOCKED  = 2'b11;

  // 640x480@60 horizontal timing, in pixel clocks
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = 800;

  // 640x480@60 vertical timing, in lines
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = 525;

endpackage

// File: rtl/sync_edge_sync.sv
// Two-flop synchroniser for an asynchronous sync line, normalised to
// active-high, plus leading (rise) and trailing (fall) edge detect.
module sync_edge_sync #(
  parameter bit POL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       lvl_d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= {2{~POL}};
      lvl_d_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], d};
      lvl_d_q <= level;
    end
  end

  assign level = (sync_q[1] == POL);
  assign rise  = level & ~lvl_d_q;
  assign fall  = ~level & lvl_d_q;

endmodule

// File: rtl/sync_timing_detect.sv
// Measures period and pulse width of one sync line and declares lock after
// LOCK_FRAMES consecutive matching periods; exposes position since the edge.
module sync_timing_detect
  import vga_timing_pkg::*;
#(
  parameter int WIDTH       = 11,
  parameter bit SYNC_POL    = 1'b1,
  parameter int LOCK_FRAMES = 2,
  parameter int TOLERANCE   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sync_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] pulse_width,
  output logic [WIDTH-1:0] position,
  output logic             locked,
  output logic             lost,
  output logic             edge_strobe
);

  localparam logic [WIDTH-1:0] CNT_MAX    = '1;
  localparam int               MW         = $clog2(LOCK_FRAMES + 1);
  localparam logic [MW-1:0]    MATCH_GOAL = MW'(LOCK_FRAMES);

  logic             le, te, s_level_unused;
  logic [WIDTH-1:0] cnt_q, cnt_d, wcap_q, wcap_d;
  logic [WIDTH-1:0] ref_p_q, ref_p_d, ref_w_q, ref_w_d;
  logic [WIDTH-1:0] period_q, period_d, pw_q, pw_d;
  logic [MW-1:0]    match_q, match_d;
  logic [1:0]       state_q, state_d;
  logic             t_seen_q, t_seen_d;
  logic             locked_q, lost_q, strobe_q;
  logic             hit;

  sync_edge_sync #(.POL(SYNC_POL)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sync_in),
    .level (s_level_unused),
    .rise  (le),
    .fall  (te)
  );

  // Difference taken one bit wider so it can never wrap.
  function automatic logic near(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] diff;
    diff = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
    return diff <= (WIDTH+1)'(TOLERANCE);
  endfunction

  always_comb begin
    state_d  = state_q;
    ref_p_d  = ref_p_q;
    ref_w_d  = ref_w_q;
    match_d  = match_q;
    period_d = period_q;
    pw_d     = pw_q;
    wcap_d   = wcap_q;
    t_seen_d = t_seen_q;
    hit      = near(cnt_q, ref_p_q) && near(wcap_q, ref_w_q);

    if (le)                   cnt_d = WIDTH'(1);
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + WIDTH'(1);
    else                      cnt_d = cnt_q;

    if (te) begin
      wcap_d   = cnt_q;
      t_seen_d = 1'b1;
    end

    // A leading edge takes priority over a simultaneous timeout.
    if (le) begin
      t_seen_d = 1'b0;
      case (state_q)
        IDLE: state_d = MEASURE;
        MEASURE: begin
          if (t_seen_q) begin
            ref_p_d = cnt_q;
            ref_w_d = wcap_q;
            match_d = '0;
            state_d = VERIFY;
          end else begin
            state_d = IDLE;
          end
        end
        VERIFY: begin
          if (hit) begin
            match_d = match_q + MW'(1);
            if (match_d == MATCH_GOAL) begin
              state_d  = LOCKED;
              period_d = cnt_q;
              pw_d     = wcap_q;
            end
          end else begin
            ref_p_d = cnt_q;
            ref_w_d = wcap_q;
            match_d = '0;
          end
        end
        default: begin
          ref_p_d = cnt_q;
          ref_w_d = wcap_q;
          if (hit) begin
            period_d = cnt_q;
            pw_d     = wcap_q;
          end else begin
            match_d = '0;
            state_d = VERIFY;
          end
        end
      endcase
    end else if (cnt_q == CNT_MAX) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wcap_q   <= '0;
      ref_p_q  <= '0;
      ref_w_q  <= '0;
      match_q  <= '0;
      t_seen_q <= 1'b0;
      period_q <= '0;
      pw_q     <= '0;
      locked_q <= 1'b0;
      lost_q   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wcap_q   <= wcap_d;
      ref_p_q  <= ref_p_d;
      ref_w_q  <= ref_w_d;
      match_q  <= match_d;
      t_seen_q <= t_seen_d;
      period_q <= period_d;
      pw_q     <= pw_d;
      locked_q <= (state_d == LOCKED);
      lost_q   <= (state_q == LOCKED) && (state_d != LOCKED);
      strobe_q <= le;
    end
  end

  assign period      = period_q;
  assign pulse_width = pw_q;
  assign position    = locked_q ? cnt_q : '0;
  assign locked      = locked_q;
  assign lost        = lost_q;
  assign edge_strobe = strobe_q;

endmodule

// File: tb/tb_sync_timing_detect.sv
// Bench for sync_timing_detect: active-high and active-low instances share
// one stimulus and are both checked every cycle against a behavioural model.
module tb_sync_timing_detect;
  import vga_timing_pkg::*;

  localparam int W    = 11;
  localparam int LF   = 2;
  localparam int TOL  = 1;
  localparam int MAXC = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sync_p = 1'b0;
  logic         sync_n;
  logic [W-1:0] per_p, pw_p, pos_p, per_n, pw_n, pos_n;
  logic         lk_p, lo_p, es_p, lk_n, lo_n, es_n;

  assign sync_n = ~sync_p;
  always #5 clk = ~clk;

  sync_timing_detect #(.WIDTH(W), .SYNC_POL(1'b1), .LOCK_FRAMES(LF), .TOLERANCE(TOL)) dut_p (
    .clk(clk), .reset(reset), .sync_in(sync_p), .period(per_p), .pulse_width(pw_p),
    .position(pos_p), .locked(lk_p), .lost(lo_p), .edge_strobe(es_p));

  sync_timing_detect #(.WIDTH(W), .SYNC_POL(1'b0), .LOCK_FRAMES(LF), .TOLERANCE(TOL)) dut_n (
    .clk(clk), .reset(reset), .sync_in(sync_n), .period(per_n), .pulse_width(pw_n),
    .position(pos_n), .locked(lk_n), .lost(lo_n), .edge_strobe(es_n));

  int n_tests = 0;
  int n_fail  = 0;
  int lost_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: tracks time since the last leading edge, the length
  // of the last active run, and the lock rules expressed on whole periods.
  int  age, wcap_m, ref_p, ref_w, streak, out_p, out_w;
  bit  prev_s, seen_edge, seen_fall, ref_valid, lk_m, lost_m, es_m;
  bit  dq[$];

  function automatic bit near(input int a, input int b);
    return ((a > b) ? a - b : b - a) <= TOL;
  endfunction

  task automatic model_reset();
    age = 0; wcap_m = 0; ref_p = 0; ref_w = 0; streak = 0; out_p = 0; out_w = 0;
    prev_s = 0; seen_edge = 0; seen_fall = 0; ref_valid = 0; lk_m = 0; lost_m = 0; es_m = 0;
    dq = {1'b0, 1'b0};
  endtask

  task automatic edge_event(input int p, input int w);
    bit m;
    m = ref_valid && near(p, ref_p) && near(w, ref_w);
    if (lk_m) begin
      if (m) begin out_p = p; out_w = w; end
      else begin lk_m = 0; lost_m = 1; streak = 0; end
      ref_p = p; ref_w = w;
    end else if (ref_valid) begin
      if (m) begin
        streak++;
        if (streak == LF) begin lk_m = 1; out_p = p; out_w = w; end
      end else begin
        ref_p = p; ref_w = w; streak = 0;
      end
    end else if (seen_edge) begin
      if (seen_fall) begin ref_valid = 1; ref_p = p; ref_w = w; streak = 0; end
      else seen_edge = 0;
    end else begin
      seen_edge = 1;
    end
  endtask

  task automatic consume(input bit s);
    bit lead, trail;
    lead  = s && !prev_s;
    trail = !s && prev_s;
    lost_m = 0;
    es_m   = lead;
    if (lead) begin
      edge_event(age, wcap_m);
      seen_fall = 0;
      age = 1;
    end else begin
      if (age == MAXC) begin
        if (lk_m) lost_m = 1;
        lk_m = 0; ref_valid = 0; seen_edge = 0; streak = 0;
      end
      if (trail) begin wcap_m = age; seen_fall = 1; end
      if (age < MAXC) age++;
    end
    prev_s = s;
  endtask

  task automatic check_outputs();
    int pos_e;
    pos_e = lk_m ? age : 0;
    if (lo_p) lost_seen++;
    chk("locked_p", lk_p, lk_m);   chk("locked_n", lk_n, lk_m);
    chk("lost_p", lo_p, lost_m);   chk("lost_n", lo_n, lost_m);
    chk("strobe_p", es_p, es_m);   chk("strobe_n", es_n, es_m);
    chk("period_p", per_p, out_p); chk("period_n", per_n, out_p);
    chk("width_p", pw_p, out_w);   chk("width_n", pw_n, out_w);
    chk("pos_p", pos_p, pos_e);    chk("pos_n", pos_n, pos_e);
  endtask

  // Outputs seen at a falling edge reflect the sample driven three cycles earlier.
  task automatic step(input bit v);
    @(negedge clk);
    if (dq.size() == 3) consume(dq.pop_front());
    check_outputs();
    sync_p = v;
    dq.push_back(v);
  endtask

  task automatic pulse(input int p, input int w);
    for (int i = 0; i < w; i++) step(1'b1);
    for (int i = w; i < p; i++) step(1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    sync_p = 1'b0;
    dq.push_back(1'b0);
  endtask

  initial begin
    int lost_before;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_locked", lk_p, 0); chk("rst_period", per_p, 0);
    chk("rst_pos", pos_n, 0);   chk("rst_strobe", es_p, 0);
    release_reset();

    // Nominal H timing: lock one clock after the 4th leading edge
    repeat (3) pulse(H_TOTAL, H_SYNC);
    chk("t1_prelock", lk_p, 0);
    pulse(H_TOTAL, H_SYNC);
    chk("t1_lock", lk_p, 1);   chk("t1_period", per_p, 800);
    chk("t1_width", pw_p, 96); chk("t1_lock_n", lk_n, 1); chk("t1_width_n", pw_n, 96);

    // One-count jitter stays locked
    pulse(799, 96); pulse(800, 96);
    chk("t2_locked", lk_p, 1); chk("t2_period799", per_p, 799);
    pulse(800, 96);
    chk("t2_period800", per_p, 800);

    // Large error drops lock, three good periods relock
    pulse(810, 96);
    lost_before = lost_seen;
    repeat (3) pulse(800, 96);
    chk("t3_unlocked", lk_p, 0); chk("t3_one_lost", lost_seen - lost_before, 1);
    pulse(800, 96);
    chk("t3_relock", lk_p, 1);   chk("t3_period", per_p, 800);

    // Sync stops: counter saturates and lock is dropped
    pulse(800, 96);
    lost_before = lost_seen;
    repeat (2100) step(1'b0);
    chk("t4_unlocked", lk_p, 0); chk("t4_pos", pos_p, 0);
    chk("t4_one_lost", lost_seen - lost_before, 1);

    // Reset in the middle of a locked pulse
    repeat (4) pulse(800, 96);
    chk("t5_prelock", lk_p, 1);
    repeat (40) step(1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_locked", lk_p, 0); chk("t5_rst_lost", lo_p, 0);
    chk("t5_rst_period", per_p, 0); chk("t5_rst_pos", pos_p, 0);
    chk("t5_rst_width_n", pw_n, 0); chk("t5_rst_strobe", es_n, 0);
    sync_p = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t5_hold_lost", lo_p, 0);
    end
    release_reset();
    repeat (3) pulse(800, 96);
    chk("t5_prelock2", lk_p, 0);
    pulse(800, 96);
    chk("t5_relock", lk_p, 1); chk("t5_period", per_p, 800);

    // Random jitter and occasional glitches around nominal H timing
    repeat (14) begin
      int p, w;
      p = 799 + int'($urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0) p = 780 + int'($urandom_range(0, 40));
      w = 94 + int'($urandom_range(0, 4));
      pulse(p, w);
    end

    // Random short timings with small jitter bursts
    repeat (10) begin
      int p0, w0, n;
      p0 = int'($urandom_range(20, 80));
      w0 = int'($urandom_range(1, p0 - 4));
      n  = int'($urandom_range(3, 7));
      for (int k = 0; k < n; k++) begin
        int p, w;
        p = p0 + int'($urandom_range(0, 4)) - 2;
        w = w0 + int'($urandom_range(0, 1));
        pulse(p, w);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
